// File: rtl/demux_frame_seq_if.sv
// Frame handshake and demux drive bundle between an upstream frame source and the sequencer.
// Latency: none (wires only).
// Backpressure: in_ready gates in_valid; d/x/out_valid/frame_done/busy are pure outputs.
// Ports: in_valid/in_ready/in_data frame handshake, abort cancel, d/x demux drive,
//        out_valid live-channel flag, frame_done completion pulse, busy frame-in-progress flag.
interface demux_frame_seq_if;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_data;
    logic       abort;
    logic       d;
    logic [1:0] x;
    logic       out_valid;
    logic       frame_done;
    logic       busy;

    // Frame source side.
    modport master (
        output in_valid, in_data, abort,
        input  in_ready, d, x, out_valid, frame_done, busy
    );

    // Sequencer side.
    modport slave (
        input  in_valid, in_data, abort,
        output in_ready, d, x, out_valid, frame_done, busy
    );
endinterface

// File: rtl/demux_frame_seq.sv
// Latches a 4-bit frame and walks the demux select x through channels 0..3, driving d = frame[x].
// Latency: channel 0 is on the outputs the cycle after acceptance; frame_done pulses 4*DWELL+1 cycles after acceptance.
// Backpressure: in_ready is low for the whole frame (DRIVE and DONE); offers while low are ignored.
// Ports: clk, rst_n (sync, active-low); bus = slave side of demux_frame_seq_if.
module demux_frame_seq #(
    parameter int unsigned DWELL = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    demux_frame_seq_if.slave     bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);

    state_t     r_state;
    logic [3:0] r_frame;
    logic [1:0] r_ch;
    logic [7:0] r_dwell_cnt;

    logic       r_d;
    logic [1:0] r_x;
    logic       r_out_valid;
    logic       r_frame_done;
    logic       r_busy;
    logic       r_in_ready;

    logic [1:0] w_ch_nxt;
    logic       w_accept;

    assign w_ch_nxt = r_ch + 2'd1;
    // abort in IDLE blocks the transfer on that edge.
    assign w_accept = bus.in_valid && r_in_ready && !bus.abort;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_frame      <= 4'd0;
            r_ch         <= 2'd0;
            r_dwell_cnt  <= 8'd0;
            r_d          <= 1'b0;
            r_x          <= 2'd0;
            r_out_valid  <= 1'b0;
            r_frame_done <= 1'b0;
            r_busy       <= 1'b0;
            r_in_ready   <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        // Outputs are registered, so channel 0 is loaded straight from in_data.
                        r_state     <= S_DRIVE;
                        r_frame     <= bus.in_data;
                        r_ch        <= 2'd0;
                        r_dwell_cnt <= 8'd0;
                        r_out_valid <= 1'b1;
                        r_x         <= 2'd0;
                        r_d         <= bus.in_data[0];
                        r_busy      <= 1'b1;
                        r_in_ready  <= 1'b0;
                    end
                end

                S_DRIVE: begin
                    if (bus.abort) begin
                        r_state     <= S_IDLE;
                        r_ch        <= 2'd0;
                        r_dwell_cnt <= 8'd0;
                        r_out_valid <= 1'b0;
                        r_x         <= 2'd0;
                        r_d         <= 1'b0;
                        r_busy      <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end else if (r_dwell_cnt == DWELL_LAST) begin
                        r_dwell_cnt <= 8'd0;
                        if (r_ch == 2'd3) begin
                            // Last channel expired: ch is left at 3 rather than wrapping.
                            r_state      <= S_DONE;
                            r_out_valid  <= 1'b0;
                            r_x          <= 2'd0;
                            r_d          <= 1'b0;
                            r_frame_done <= 1'b1;
                        end else begin
                            // x and d move together so d is never stale while out_valid=1.
                            r_ch <= w_ch_nxt;
                            r_x  <= w_ch_nxt;
                            r_d  <= r_frame[w_ch_nxt];
                        end
                    end else begin
                        r_dwell_cnt <= r_dwell_cnt + 8'd1;
                    end
                end

                S_DONE: begin
                    // abort here changes nothing: the pulse already went out this cycle.
                    r_state      <= S_IDLE;
                    r_ch         <= 2'd0;
                    r_frame_done <= 1'b0;
                    r_busy       <= 1'b0;
                    r_in_ready   <= 1'b1;
                end

                default: begin
                    r_state      <= S_IDLE;
                    r_ch         <= 2'd0;
                    r_dwell_cnt  <= 8'd0;
                    r_out_valid  <= 1'b0;
                    r_x          <= 2'd0;
                    r_d          <= 1'b0;
                    r_frame_done <= 1'b0;
                    r_busy       <= 1'b0;
                    r_in_ready   <= 1'b1;
                end
            endcase
        end
    end

    assign bus.d          = r_d;
    assign bus.x          = r_x;
    assign bus.out_valid  = r_out_valid;
    assign bus.frame_done = r_frame_done;
    assign bus.busy       = r_busy;
    assign bus.in_ready   = r_in_ready;

endmodule

// File: tb/tb_demux_frame_seq.sv
// Bench for demux_frame_seq: a DWELL=2 instance and a DWELL=1 instance on a shared clock and reset.
// Latency: n/a.
// Backpressure: n/a.
module tb_demux_frame_seq;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    demux_frame_seq_if bus2 ();
    demux_frame_seq_if bus1 ();

    demux_frame_seq #(.DWELL(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));
    demux_frame_seq #(.DWELL(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    int n_cmp  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: a frame is just (active, cycles since acceptance t, frame bits).
    // Outputs follow from t: t < 4*DWELL drives channel t/DWELL, t == 4*DWELL is the done cycle.
    typedef struct packed {
        logic        act;
        logic [15:0] t;
        logic [3:0]  fr;
    } mst_t;

    mst_t m2 = '0;
    mst_t m1 = '0;

    function automatic mst_t mstep(mst_t s, int dw, logic rn, logic iv, logic ab, logic [3:0] id);
        mst_t n;
        n = s;
        if (!rn) begin
            n = '0;
        end else if (s.act) begin
            if (ab || int'(s.t) == 4 * dw) n.act = 1'b0;
            else                           n.t   = s.t + 16'd1;
        end else if (iv && !ab) begin
            n.act = 1'b1;
            n.t   = 16'd0;
            n.fr  = id;
        end
        return n;
    endfunction

    // Packed as {in_ready, busy, frame_done, out_valid, x[1:0], d}.
    function automatic logic [6:0] exp_out(mst_t s, int dw);
        int ch;
        if (!s.act) return 7'b1000000;
        if (int'(s.t) < 4 * dw) begin
            ch = int'(s.t) / dw;
            return {1'b0, 1'b1, 1'b0, 1'b1, 2'(ch), s.fr[ch]};
        end
        return 7'b0110000;
    endfunction

    always @(posedge clk) begin
        m2 <= mstep(m2, 2, rst_n, bus2.in_valid, bus2.abort, bus2.in_data);
        m1 <= mstep(m1, 1, rst_n, bus1.in_valid, bus1.abort, bus1.in_data);
    end

    always @(negedge clk) begin
        if (chk_en) begin
            cmp("model_dwell2", {bus2.in_ready, bus2.busy, bus2.frame_done, bus2.out_valid, bus2.x, bus2.d},
                exp_out(m2, 2));
            cmp("model_dwell1", {bus1.in_ready, bus1.busy, bus1.frame_done, bus1.out_valid, bus1.x, bus1.d},
                exp_out(m1, 1));
        end
    end

    // Event recorders: acceptance edges and frame_done pulses.
    int cyc = 0;
    int acc2[$];
    int acc1[$];
    int done2 = 0;
    int done1 = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_n && bus2.in_valid && bus2.in_ready && !bus2.abort) acc2.push_back(cyc);
        if (rst_n && bus1.in_valid && bus1.in_ready && !bus1.abort) acc1.push_back(cyc);
    end

    always @(negedge clk) begin
        if (bus2.frame_done === 1'b1) done2++;
        if (bus1.frame_done === 1'b1) done1++;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle2(input string nm);
        int n;
        n = 0;
        while (bus2.in_ready !== 1'b1 && n < 40) begin tick(); n++; end
        cmp(nm, bus2.in_ready, 1);
    endtask

    task automatic wait_idle1(input string nm);
        int n;
        n = 0;
        while (bus1.in_ready !== 1'b1 && n < 40) begin tick(); n++; end
        cmp(nm, bus1.in_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [1:0] xs2 [8];
        logic       ds2 [8];
        logic       ds4 [8];
        logic       ds6 [4];
        int a0;
        int dn0;

        xs2 = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3};
        ds2 = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        ds4 = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        ds6 = '{1'b1, 1'b0, 1'b1, 1'b0};

        // 1. Reset with in_valid held high.
        rst_n = 1'b0;
        bus2.in_valid = 1'b1; bus2.in_data = 4'b1111; bus2.abort = 1'b0;
        bus1.in_valid = 1'b1; bus1.in_data = 4'b1111; bus1.abort = 1'b0;
        tick();
        chk_en = 1'b1;
        tick();
        tick();
        cmp("rst_outputs2", {bus2.in_ready, bus2.busy, bus2.frame_done, bus2.out_valid, bus2.x, bus2.d}, 7'b1000000);
        cmp("rst_outputs1", {bus1.in_ready, bus1.busy, bus1.frame_done, bus1.out_valid, bus1.x, bus1.d}, 7'b1000000);
        cmp("rst_no_accept", acc2.size() + acc1.size(), 0);
        rst_n = 1'b1;
        bus2.in_valid = 1'b0;
        bus1.in_valid = 1'b0;
        tick();
        cmp("rst_release_ready", bus2.in_ready, 1);

        // 2. Single frame, DWELL=2.
        dn0 = done2;
        bus2.in_valid = 1'b1; bus2.in_data = 4'b1010;
        tick();
        bus2.in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cmp($sformatf("t2_vxd_%0d", i), {bus2.out_valid, bus2.x, bus2.d}, {1'b1, xs2[i], ds2[i]});
            tick();
        end
        cmp("t2_frame_done", {bus2.frame_done, bus2.out_valid}, 2'b10);
        tick();
        cmp("t2_ready_back", {bus2.in_ready, bus2.frame_done}, 2'b10);
        cmp("t2_one_pulse", done2 - dn0, 1);

        // 3. Back-to-back with in_valid held.
        a0 = acc2.size(); dn0 = done2;
        bus2.in_valid = 1'b1; bus2.in_data = 4'b1111;
        tick();
        begin
            int n;
            n = 0;
            while (bus2.in_ready !== 1'b1 && n < 30) begin tick(); n++; end
        end
        bus2.in_data = 4'b0001;
        tick();
        bus2.in_valid = 1'b0;
        cmp("t3_accepts", acc2.size() - a0, 2);
        if (acc2.size() - a0 >= 2) cmp("t3_spacing", acc2[a0 + 1] - acc2[a0], 10);
        wait_idle2("t3_idle");
        cmp("t3_done_pulses", done2 - dn0, 2);

        // 4. in_data/in_valid activity while busy is ignored.
        a0 = acc2.size();
        bus2.in_valid = 1'b1; bus2.in_data = 4'b0110;
        tick();
        bus2.in_data = 4'b1001;
        for (int i = 0; i < 8; i++) begin
            cmp($sformatf("t4_d_%0d", i), bus2.d, ds4[i]);
            tick();
        end
        cmp("t4_done", bus2.frame_done, 1);
        cmp("t4_no_early_accept", acc2.size() - a0, 1);
        begin
            int n;
            n = 0;
            while (bus2.in_ready !== 1'b1 && n < 30) begin tick(); n++; end
        end
        tick();
        bus2.in_valid = 1'b0;
        cmp("t4_accepts", acc2.size() - a0, 2);
        if (acc2.size() - a0 >= 2) cmp("t4_spacing", acc2[a0 + 1] - acc2[a0], 10);
        wait_idle2("t4_idle");

        // 5. Abort while x=2, then abort in IDLE blocks acceptance.
        dn0 = done2;
        bus2.in_valid = 1'b1; bus2.in_data = 4'b1111;
        tick();
        bus2.in_valid = 1'b0;
        repeat (4) tick();
        cmp("t5_at_ch2", {bus2.out_valid, bus2.x}, 3'b110);
        bus2.abort = 1'b1;
        tick();
        bus2.abort = 1'b0;
        cmp("t5_after_abort", {bus2.out_valid, bus2.d, bus2.x, bus2.in_ready, bus2.busy}, 6'b000010);
        repeat (10) tick();
        cmp("t5_no_done", done2 - dn0, 0);
        a0 = acc2.size();
        bus2.in_valid = 1'b1; bus2.abort = 1'b1;
        tick();
        bus2.in_valid = 1'b0; bus2.abort = 1'b0;
        cmp("t5_idle_abort_blocks", {bus2.in_ready, bus2.busy}, 2'b10);
        cmp("t5_idle_abort_count", acc2.size() - a0, 0);

        // Reset mid-frame: no completion pulse.
        dn0 = done2;
        bus2.in_valid = 1'b1; bus2.in_data = 4'b1111;
        tick();
        bus2.in_valid = 1'b0;
        repeat (3) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        cmp("rst_mid_frame", {bus2.in_ready, bus2.busy, bus2.out_valid}, 3'b100);
        repeat (10) tick();
        cmp("rst_mid_no_done", done2 - dn0, 0);

        // 6. DWELL=1 instance.
        a0 = acc1.size(); dn0 = done1;
        bus1.in_valid = 1'b1; bus1.in_data = 4'b0101;
        tick();
        bus1.in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cmp($sformatf("t6_vxd_%0d", i), {bus1.out_valid, bus1.x, bus1.d}, {1'b1, 2'(i), ds6[i]});
            tick();
        end
        cmp("t6_done_at_4", bus1.frame_done, 1);
        tick();
        cmp("t6_ready_back", bus1.in_ready, 1);
        bus1.in_valid = 1'b1;
        tick();
        begin
            int n;
            n = 0;
            while (bus1.in_ready !== 1'b1 && n < 30) begin tick(); n++; end
        end
        tick();
        bus1.in_valid = 1'b0;
        cmp("t6_accepts", acc1.size() - a0, 3);
        if (acc1.size() - a0 >= 3) cmp("t6_period", acc1[a0 + 2] - acc1[a0 + 1], 6);
        wait_idle1("t6_idle");
        cmp("t6_done_pulses", done1 - dn0, 3);

        repeat (2) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/demux_frame_seq.md
# demux_frame_seq

Upstream driver for the 2x4 demultiplexer stage. Accepts a 4-bit frame over a valid/ready handshake, latches it, then walks the demux select through channels 0..3. For each channel it drives the demux data input with the matching frame bit for a programmable number of cycles. It signals completion with a one-cycle pulse and then accepts the next frame.

## Interface
- DWELL, default 2: cycles each channel is held on the outputs; legal range 1..255.
- clk  in  1  single system clock; all state changes on rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- in_valid  in  1  frame offered.
- in_ready  out  1  block can accept a frame this cycle.
- in_data  in  4  frame; bit i is routed to demux channel i.
- abort  in  1  synchronous cancel of the current frame.
- d  out  1  demux data input.
- x  out  2  demux channel select.
- out_valid  out  1  d and x carry a live channel this cycle.
- frame_done  out  1  one-cycle pulse after channel 3 completes.
- busy  out  1  frame in progress (DRIVE or DONE).

## Operation
- FSM states: IDLE, DRIVE, DONE. All outputs are registered.
- IDLE behaviour:
  - in_ready=1, out_valid=0, d=0, x=0, busy=0.
  - On in_valid && in_ready: latch in_data into frame_reg. Next state is DRIVE, with ch=0 and dwell_cnt=0.
- DRIVE behaviour:
  - out_valid=1, x=ch, d=frame_reg[ch], busy=1, in_ready=0.
  - dwell_cnt increments each cycle. When dwell_cnt==DWELL-1 it clears and ch increments.
  - When ch==3 and dwell_cnt==DWELL-1, next state is DONE.
- DONE behaviour:
  - frame_done=1, out_valid=0, d=0, x=0, busy=1, in_ready=0.
  - Next state is IDLE unconditionally.
- Handshake:
  - A transfer occurs only on a cycle where in_valid && in_ready at the rising edge.
  - in_valid or in_data activity while in_ready=0 is ignored and has no side effects.
  - in_data changes after acceptance do not affect the frame in flight.
- abort:
  - Sampled every edge. In DRIVE or DONE, next state is IDLE and all outputs are zeroed.
  - No frame_done is produced on an aborted frame. If the abort lands in DONE, the frame_done already asserted in that cycle stands.
  - abort in IDLE takes priority over acceptance: no transfer occurs that cycle.
- Reset has priority over abort and handshake.
- dwell_cnt is 8 bits wide; it never exceeds DWELL-1.
- ch is 2 bits wide and never wraps mid-frame; it is reset to 0 on every acceptance.

## Timing
- Reset: on a rising edge with rst_n=0, the next state is IDLE with d=0, x=0, out_valid=0, frame_done=0, busy=0, in_ready=1, frame_reg=0, ch=0, dwell_cnt=0.
- Reset mid-frame behaves identically; no frame_done is produced.
- Latency: frame accepted at edge k gives channel 0 on the outputs from edge k through edge k+DWELL.
- Channel n is valid for cycles k+n·DWELL .. k+(n+1)·DWELL-1, referenced to the edge following acceptance.
- frame_done is high for the single cycle after edge k+4·DWELL.
- in_ready returns high at edge k+4·DWELL+1.
- Minimum frame period: 4·DWELL+2 cycles (accept cycle + 4·DWELL drive cycles + 1 DONE cycle).
- x and d change together on the same edge; there is never a cycle with out_valid=1 and stale d.

## Test plan
1. Reset: hold rst_n=0 for 3 cycles with in_valid=1, then release. Required: all outputs at their reset values during reset, in_ready=1 after release, no acceptance while rst_n=0.
2. Single frame: DWELL=2, in_data=4'b1010, one-cycle valid. Required (x,d) per cycle: (0,0),(0,0),(1,1),(1,1),(2,0),(2,0),(3,1),(3,1), then frame_done=1 for 1 cycle, then in_ready=1.
3. Back-to-back: in_valid held high with 4'b1111 then 4'b0001. Required: second frame accepted exactly 10 cycles after the first; the sequences do not overlap; there are 2 frame_done pulses.
4. Ignore while busy: accept 4'b0110, then change in_data to 4'b1001 with in_valid=1 during DRIVE. Required: driven bits remain 0,1,1,0, and the next acceptance occurs only after DONE.
5. Abort: assert abort for 1 cycle while x=2. Required: next cycle out_valid=0, d=0, x=0, in_ready=1, and no frame_done pulse.
6. DWELL=1 build with in_data=4'b0101. Required: d=1,0,1,0 on x=0..3 for one cycle each, frame_done 4 cycles after acceptance, and a 6-cycle minimum period.
